// File: rtl/voice_echo_adder.sv
// Feed-forward echo generator: y[n] = sat(x[n] + (x[n-DELAY_DEPTH] >>> GAIN_SHIFT)).
// Circular delay line in inferred RAM; two-cycle latency from data_in_valid to data_out_valid.
module voice_echo_adder #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 10,
  parameter int DELAY_DEPTH = 1024,
  parameter int GAIN_SHIFT  = 1
) (
  input  logic                  sck,
  input  logic                  rst_n,
  input  logic                  data_in_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  echo_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  output logic                  primed
);

  typedef enum logic {FILL, RUN} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DELAY_DEPTH - 1);
  localparam logic [DATA_WIDTH-1:0] SAT_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t                  state_reg;
  logic [ADDR_WIDTH-1:0]   wr_ptr_reg;
  logic [ADDR_WIDTH-1:0]   fill_cnt_reg;
  logic [DATA_WIDTH-1:0]   x_reg;
  logic                    c1_valid_reg;
  logic                    c1_run_reg;

  logic [DATA_WIDTH-1:0]   mem [DELAY_DEPTH];
  logic [DATA_WIDTH-1:0]   rd_data_reg;

  logic signed [DATA_WIDTH-1:0] echo_term;
  logic [DATA_WIDTH:0]          sum_next;
  logic [DATA_WIDTH-1:0]        sat_next;

  // Read-before-write: the slot about to be overwritten holds x[n-DELAY_DEPTH].
  always_ff @(posedge sck) begin
    if (data_in_valid) begin
      rd_data_reg     <= mem[wr_ptr_reg];
      mem[wr_ptr_reg] <= data_in;
    end
  end

  always_comb begin
    echo_term = '0;
    // c1_run_reg records whether the read was of a genuinely filled slot.
    if (c1_run_reg && echo_en) begin
      echo_term = $signed(rd_data_reg) >>> GAIN_SHIFT;
    end
    sum_next = {x_reg[DATA_WIDTH-1], x_reg} + {echo_term[DATA_WIDTH-1], echo_term};
    if (sum_next[DATA_WIDTH] != sum_next[DATA_WIDTH-1]) begin
      sat_next = sum_next[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    end else begin
      sat_next = sum_next[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= FILL;
      wr_ptr_reg     <= '0;
      fill_cnt_reg   <= '0;
      primed         <= 1'b0;
      x_reg          <= '0;
      c1_valid_reg   <= 1'b0;
      c1_run_reg     <= 1'b0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else begin
      c1_valid_reg   <= data_in_valid;
      data_out_valid <= c1_valid_reg;
      if (c1_valid_reg) begin
        data_out <= sat_next;
      end
      if (data_in_valid) begin
        x_reg      <= data_in;
        c1_run_reg <= (state_reg == RUN);
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        case (state_reg)
          FILL: begin
            fill_cnt_reg <= fill_cnt_reg + 1'b1;
            if (fill_cnt_reg == LAST_IDX) begin
              state_reg <= RUN;
              primed    <= 1'b1;
            end
          end
          RUN: begin
            state_reg <= RUN;
          end
          default: begin
            state_reg <= FILL;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_voice_echo_adder.sv
// Directed-vector bench for voice_echo_adder with an 8-sample delay line.
module tb_voice_echo_adder;

  logic        sck;
  logic        rst_n;
  logic        data_in_valid;
  logic [15:0] data_in;
  logic        echo_en;
  logic [15:0] data_out;
  logic        data_out_valid;
  logic        primed;

  int vectors;
  int miscompares;

  // Expected-output pipeline mirroring the two-cycle latency; entries are hand values.
  logic               lat_v [2];
  logic signed [15:0] lat_d [2];
  logic signed [15:0] hold_d;
  logic               exp_v;
  logic signed [15:0] exp_d;
  logic               en_prev;

  // Stimulus list: valid, sample, echo_en for that sample's C1, expected output.
  logic               qv  [$];
  logic signed [15:0] qx  [$];
  logic               qen [$];
  logic signed [15:0] qe  [$];

  voice_echo_adder #(
    .DATA_WIDTH (16),
    .ADDR_WIDTH (3),
    .DELAY_DEPTH(8),
    .GAIN_SHIFT (1)
  ) dut (
    .sck           (sck),
    .rst_n         (rst_n),
    .data_in_valid (data_in_valid),
    .data_in       (data_in),
    .echo_en       (echo_en),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .primed        (primed)
  );

  initial sck = 1'b0;
  always #5 sck = ~sck;

  task automatic clear_list();
    qv.delete(); qx.delete(); qen.delete(); qe.delete();
  endtask

  task automatic push_samp(input int x, input logic en, input int e);
    qv.push_back(1'b1); qx.push_back(16'(x)); qen.push_back(en); qe.push_back(16'(e));
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) begin
      qv.push_back(1'b0); qx.push_back(16'sd0); qen.push_back(1'b1); qe.push_back(16'sd0);
    end
  endtask

  // echo_en is sampled one cycle after the sample, so it is driven one tick late.
  task automatic tick(input logic v, input logic signed [15:0] x, input logic en,
                      input logic signed [15:0] e);
    @(negedge sck);
    data_in_valid = v;
    data_in       = v ? x : 16'd0;
    echo_en       = en_prev;
    en_prev       = en;
    exp_v = lat_v[1];
    if (lat_v[1]) hold_d = lat_d[1];
    exp_d = hold_d;
    lat_v[1] = lat_v[0]; lat_d[1] = lat_d[0];
    lat_v[0] = v;        lat_d[0] = e;
  endtask

  task automatic reset_dut();
    @(negedge sck);
    rst_n = 1'b0; data_in_valid = 1'b0; data_in = 16'd0; echo_en = 1'b0;
    lat_v[0] = 1'b0; lat_v[1] = 1'b0; hold_d = 16'sd0; en_prev = 1'b0;
    @(negedge sck);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; data_in_valid = 1'b0; data_in = 16'd0; echo_en = 1'b1; en_prev = 1'b1;
    lat_v[0] = 1'b0; lat_v[1] = 1'b0; hold_d = 16'sd0;
    repeat (2) @(negedge sck);
    vectors++;
    if (data_out !== 16'd0) begin
      miscompares++; $display("FAIL reset_data_out: got %0d, want 0", $signed(data_out));
    end
    vectors++;
    if (data_out_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_valid: got %b, want 0", data_out_valid);
    end
    vectors++;
    if (primed !== 1'b0) begin
      miscompares++; $display("FAIL reset_primed: got %b, want 0", primed);
    end
    $display("reset: data_out=%0d valid=%b primed=%b", $signed(data_out), data_out_valid, primed);
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    clear_list();
    for (int k = 0; k < 8; k++) push_samp(100, 1'b1, 100);
    push_idle(2);
    for (int k = 0; k < qv.size(); k++) begin
      tick(qv[k], qx[k], qen[k], qe[k]);
      vectors++;
      if (data_out_valid !== exp_v || data_out !== exp_d) begin
        miscompares++;
        $display("FAIL fill[%0d]: got valid=%b data=%0d, want valid=%b data=%0d",
                 k, data_out_valid, $signed(data_out), exp_v, exp_d);
      end else if (exp_v) $display("fill[%0d]: data_out=%0d", k, exp_d);
      if (k == 7 || k == 8) begin
        vectors++;
        if (primed !== (k == 8)) begin
          miscompares++; $display("FAIL fill_primed[%0d]: got %b, want %b", k, primed, (k == 8));
        end
      end
    end
  endtask

  task automatic test_impulse();
    clear_list();
    for (int k = 0; k < 8; k++) push_samp(0, 1'b1, 50);
    push_samp(1000, 1'b1, 1000);
    for (int k = 0; k < 7; k++) push_samp(0, 1'b1, 0);
    push_samp(0, 1'b1, 500);
    push_samp(0, 1'b1, 0);
    push_samp(-1001, 1'b1, -1001);
    for (int k = 0; k < 7; k++) push_samp(0, 1'b1, 0);
    push_samp(0, 1'b1, -501);
    for (int k = 0; k < qv.size(); k++) begin
      tick(qv[k], qx[k], qen[k], qe[k]);
      vectors++;
      if (data_out_valid !== exp_v || data_out !== exp_d) begin
        miscompares++;
        $display("FAIL impulse[%0d]: got valid=%b data=%0d, want valid=%b data=%0d",
                 k, data_out_valid, $signed(data_out), exp_v, exp_d);
      end else if (exp_v) $display("impulse[%0d]: data_out=%0d", k, exp_d);
    end
  endtask

  task automatic test_saturation();
    clear_list();
    for (int k = 0; k < 8; k++) push_samp(30000, 1'b1, 30000);
    for (int k = 0; k < 8; k++) push_samp(30000, 1'b1, 32767);
    for (int k = 0; k < 8; k++) push_samp(-30000, 1'b1, -15000);
    for (int k = 0; k < 8; k++) push_samp(-30000, 1'b1, -32768);
    for (int k = 0; k < qv.size(); k++) begin
      tick(qv[k], qx[k], qen[k], qe[k]);
      vectors++;
      if (data_out_valid !== exp_v || data_out !== exp_d) begin
        miscompares++;
        $display("FAIL saturation[%0d]: got valid=%b data=%0d, want valid=%b data=%0d",
                 k, data_out_valid, $signed(data_out), exp_v, exp_d);
      end else if (exp_v) $display("saturation[%0d]: data_out=%0d", k, exp_d);
    end
  endtask

  task automatic test_echo_en();
    int b_exp [8];
    logic b_en [8];
    b_exp = '{1000, 2001, 1002, 1003, 2006, 2007, 1006, 1007};
    b_en  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    reset_dut();
    clear_list();
    for (int k = 0; k < 8; k++) push_samp(100 * (k + 1), 1'b0, 100 * (k + 1));
    for (int k = 0; k < 8; k++) push_samp(2000 + k, 1'b0, 2000 + k);
    for (int k = 0; k < 8; k++) push_samp(1000 + k, b_en[k], b_exp[k]);
    for (int k = 0; k < qv.size(); k++) begin
      tick(qv[k], qx[k], qen[k], qe[k]);
      vectors++;
      if (data_out_valid !== exp_v || data_out !== exp_d) begin
        miscompares++;
        $display("FAIL echo_en[%0d]: got valid=%b data=%0d, want valid=%b data=%0d",
                 k, data_out_valid, $signed(data_out), exp_v, exp_d);
      end else if (exp_v) $display("echo_en[%0d]: data_out=%0d", k, exp_d);
      if (k == 7 || k == 8) begin
        vectors++;
        if (primed !== (k == 8)) begin
          miscompares++; $display("FAIL echo_en_primed[%0d]: got %b, want %b", k, primed, (k == 8));
        end
      end
    end
  endtask

  task automatic test_gaps();
    int gaps [8];
    int e_pre [8];
    gaps  = '{0, 3, 1, 5, 2, 0, 4, 1};
    e_pre = '{500, 500, 501, 501, 502, 502, 503, 503};
    clear_list();
    for (int k = 0; k < 17; k++) begin
      if (k < 8)       push_samp(0, 1'b1, e_pre[k]);
      else if (k == 8) push_samp(2000, 1'b1, 2000);
      else if (k < 16) push_samp(0, 1'b1, 0);
      else             push_samp(0, 1'b1, 1000);
      push_idle(gaps[k % 8]);
    end
    push_idle(2);
    for (int k = 0; k < qv.size(); k++) begin
      tick(qv[k], qx[k], qen[k], qe[k]);
      vectors++;
      if (data_out_valid !== exp_v || data_out !== exp_d) begin
        miscompares++;
        $display("FAIL gaps[%0d]: got valid=%b data=%0d, want valid=%b data=%0d",
                 k, data_out_valid, $signed(data_out), exp_v, exp_d);
      end else if (exp_v) $display("gaps[%0d]: data_out=%0d", k, exp_d);
    end
  endtask

  task automatic test_reset_midrun();
    int p [8];
    p = '{7, -7, 123, -123, 32767, -32768, 0, 1};
    clear_list();
    for (int k = 0; k < 10; k++) push_samp(4000, 1'b1, 4000);
    for (int k = 0; k < qv.size(); k++) begin
      tick(qv[k], qx[k], qen[k], qe[k]);
      vectors++;
      if (data_out_valid !== exp_v || data_out !== exp_d) begin
        miscompares++;
        $display("FAIL midrun_pre[%0d]: got valid=%b data=%0d, want valid=%b data=%0d",
                 k, data_out_valid, $signed(data_out), exp_v, exp_d);
      end else if (exp_v) $display("midrun_pre[%0d]: data_out=%0d", k, exp_d);
    end
    vectors++;
    if (primed !== 1'b1) begin
      miscompares++; $display("FAIL midrun_primed_before: got %b, want 1", primed);
    end
    // Two samples are in flight when reset hits.
    #2;
    rst_n = 1'b0; data_in_valid = 1'b0;
    #1;
    vectors++;
    if (primed !== 1'b0 || data_out_valid !== 1'b0 || data_out !== 16'd0) begin
      miscompares++;
      $display("FAIL midrun_reset: got primed=%b valid=%b data=%0d, want 0 0 0",
               primed, data_out_valid, $signed(data_out));
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge sck);
      vectors++;
      if (data_out_valid !== 1'b0) begin
        miscompares++; $display("FAIL midrun_stray_valid[%0d]: got %b, want 0", i, data_out_valid);
      end
    end
    rst_n = 1'b1;
    lat_v[0] = 1'b0; lat_v[1] = 1'b0; hold_d = 16'sd0; en_prev = 1'b1;
    clear_list();
    for (int k = 0; k < 8; k++) push_samp(p[k], 1'b1, p[k]);
    push_samp(0, 1'b1, 3);
    push_idle(2);
    for (int k = 0; k < qv.size(); k++) begin
      tick(qv[k], qx[k], qen[k], qe[k]);
      vectors++;
      if (data_out_valid !== exp_v || data_out !== exp_d) begin
        miscompares++;
        $display("FAIL midrun_post[%0d]: got valid=%b data=%0d, want valid=%b data=%0d",
                 k, data_out_valid, $signed(data_out), exp_v, exp_d);
      end else if (exp_v) $display("midrun_post[%0d]: data_out=%0d", k, exp_d);
      if (k == 7 || k == 8) begin
        vectors++;
        if (primed !== (k == 8)) begin
          miscompares++; $display("FAIL midrun_primed[%0d]: got %b, want %b", k, primed, (k == 8));
        end
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_fill();
    test_impulse();
    test_saturation();
    test_echo_en();
    test_gaps();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
